pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
Controls the iCE40 PLL wrapper and generates the system reset for logic clocked from the PLL output. Runs on the board reference clock (12 MHz), drives the PLL RESETB/BYPASS pins and synchronises the PLL lock output. Holds the core in reset until lock has been stable for a programmable time. Retries the PLL on lock timeout or lock loss, and flags a fault after a bounded number of retries.

Parameters:
PLL_RESET_CYCLES, 16, cycles RESETB is held low per attempt (>=1)
LOCK_TIMEOUT_CYCLES, 12000, max cycles in WAIT_LOCK before retry (1 ms at 12 MHz)
STABLE_CYCLES, 1200, cycles synchronised lock must stay high before release (100 us)
MAX_RETRIES, 3, failed attempts tolerated before FAULT (>=0)
SYNC_STAGES, 2, flops in the lock synchroniser (>=2)

Ports:
clk  in  1  reference clock (12 MHz board oscillator)
reset  in  1  synchronous, active-high
pll_locked  in  1  raw PLL LOCK, asynchronous to clk
pll_resetb  out  1  to PLL RESETB, active-low
pll_bypass  out  1  to PLL BYPASS
sys_reset  out  1  active-high reset for PLL-domain logic; level, registered
ready  out  1  high in RUN (or BYPASS_RUN)
fault  out  1  sticky retry-exhausted flag
retry_count  out  $clog2(MAX_RETRIES+1)  failed attempts so far, saturating

Behaviour:
- One clock (clk); reset is synchronous and active-high. All outputs registered.
- Reset values: pll_resetb=0, pll_bypass=0, sys_reset=1, ready=0, fault=0, retry_count=0, state=PLL_RST, counter=0, synchroniser cleared.
- lock_s = last stage of the SYNC_STAGES flop chain on pll_locked. All decisions use lock_s only.
- Single down/up counter, width $clog2 of the largest cycle parameter +1, cleared on every state transition.
- PLL_RST: pll_resetb=0, sys_reset=1. After PLL_RESET_CYCLES cycles -> WAIT_LOCK. pll_resetb rises on the first WAIT_LOCK cycle.
- WAIT_LOCK: pll_resetb=1.
  - lock_s=1 -> STABLE.
  - Counter reaches LOCK_TIMEOUT_CYCLES with lock_s=0 -> attempt failed.
- STABLE:
  - lock_s=0 -> attempt failed (glitch restarts from PLL_RST).
  - Lock held for STABLE_CYCLES consecutive cycles -> RUN.
- RUN: sys_reset=0, ready=1, both updating the cycle RUN is entered.
  - lock_s=0 in RUN -> sys_reset=1 and ready=0 on the next edge, state -> PLL_RST.
  - This counts as a failed attempt.
- Attempt failed:
  - If retry_count < MAX_RETRIES: increment retry_count, -> PLL_RST.
  - Otherwise -> FAULT.
  - Simultaneous timeout and lock rise in the same cycle: lock wins, -> STABLE.
- retry_count clears only on reset. It is not cleared by reaching RUN, so repeated lock losses eventually fault.
- FAULT: fault=1, pll_resetb=0, sys_reset=1, ready=0. Terminal until reset.
- Reset asserted in any state, including mid-RUN: all outputs return to reset values on the next edge. PLL_RESET_CYCLES restarts from 0.
- sys_reset is a level signal. PLL-domain consumers synchronise its deassertion locally. This block guarantees sys_reset is never low while lock_s=0 for more than 1 cycle.

Optional Feature:
PLL_BYPASS_FALLBACK_EN
- Defined: FAULT is replaced by BYPASS_RUN.
  - pll_bypass=1, pll_resetb=0, fault=1.
  - Wait 16 cycles (bypass mux settle), then sys_reset=0 and ready=1.
  - System runs at the reference frequency. Lock input is ignored. Exit only via reset.
- Undefined: pll_bypass is tied 0 and FAULT is terminal as above.

Decomposition:
- Shared package: state encoding enum (PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT, BYPASS_RUN); constant BYPASS_SETTLE_CYCLES=16; function for counter width.
- One sub-module: lock_sync (parameterised SYNC_STAGES flop chain, reset to 0). Reused elsewhere for async status inputs.

Test Plan:
Test parameters: PLL_RESET_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2.
- Nominal: release reset, raise pll_locked at cycle 10 and hold -> pll_resetb rises at cycle 4, ready and sys_reset=0 at cycle 10+2+8+1 (±1 per the sync chain), retry_count=0.
- Lock glitch: lock high 3 cycles inside STABLE, then low -> back to PLL_RST, pll_resetb=0 for 4 cycles, retry_count=1, ready stays 0.
- Timeout: pll_locked held 0 -> three attempts of 4+20 cycles, retry_count=2, then fault=1, sys_reset=1 permanently, pll_resetb=0.
- Lock loss in RUN: drop pll_locked after ready=1 -> sys_reset=1 within SYNC_STAGES+1 cycles, retry_count increments, relock recovers to RUN.
- Reset mid-STABLE and mid-FAULT: assert reset 1 cycle -> all outputs at reset values next edge, fault and retry_count cleared.
- With PLL_BYPASS_FALLBACK_EN: pll_locked stuck 0 -> after retries, pll_bypass=1 and fault=1, ready=1 and sys_reset=0 exactly 16 cycles later.

Source files
------------

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT,
    BYPASS_RUN
  } state_t;

  localparam int BYPASS_SETTLE_CYCLES = 16;

  // Counter must hold the largest programmed interval, including the bypass settle time.
  function automatic int cnt_width(input int rst_cycles, input int timeout_cycles,
                                   input int stable_cycles);
    int m;
    m = rst_cycles;
    if (timeout_cycles > m) m = timeout_cycles;
    if (stable_cycles > m) m = stable_cycles;
    if (BYPASS_SETTLE_CYCLES > m) m = BYPASS_SETTLE_CYCLES;
    return $clog2(m) + 1;
  endfunction

  function automatic int retry_width(input int max_retries);
    return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_lock_sync.sv
// Multi-flop synchroniser for a slow asynchronous status input, cleared by reset.
module pll_reset_sequencer_lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: drives RESETB/BYPASS and holds sys_reset until lock is stable.
// Optional macro PLL_BYPASS_FALLBACK_EN replaces the terminal FAULT with a bypass run mode.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 12000,
  parameter int STABLE_CYCLES       = 1200,
  parameter int MAX_RETRIES         = 3,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 pll_locked,
  output logic                                 pll_resetb,
  output logic                                 pll_bypass,
  output logic                                 sys_reset,
  output logic                                 ready,
  output logic                                 fault,
  output logic [retry_width(MAX_RETRIES)-1:0]  retry_count
);

  localparam int CW = cnt_width(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
  localparam int RW = retry_width(MAX_RETRIES);

  localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RESET_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE       = CW'(BYPASS_SETTLE_CYCLES);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

`ifdef PLL_BYPASS_FALLBACK_EN
  localparam state_t EXHAUSTED = BYPASS_RUN;
`else
  localparam state_t EXHAUSTED = FAULT;
`endif

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [RW-1:0]   retry_n;
  logic            lock_s;
  logic            fail;
  logic            pll_resetb_n, sys_reset_n, ready_n, fault_n;

  pll_reset_sequencer_lock_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (pll_locked),
    .sync_out (lock_s)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    retry_n = retry_count;
    fail    = 1'b0;

    case (state)
      PLL_RST: begin
        if (cnt == RST_LAST) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end
      end
      // Lock is tested before the timeout so a coincident lock rise wins.
      WAIT_LOCK: begin
        if (lock_s) begin
          state_n = STABLE;
          cnt_n   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          fail = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          fail = 1'b1;
        end else if (cnt == STABLE_LAST) begin
          state_n = RUN;
          cnt_n   = '0;
        end
      end
      RUN: begin
        cnt_n = '0;
        if (!lock_s) fail = 1'b1;
      end
      FAULT: begin
        cnt_n = '0;
      end
      BYPASS_RUN: begin
        cnt_n = (cnt == SETTLE) ? cnt : cnt + 1'b1;
      end
      default: begin
        state_n = PLL_RST;
        cnt_n   = '0;
      end
    endcase

    // retry_count never resets on reaching RUN, so repeated lock losses eventually exhaust it.
    if (fail) begin
      cnt_n = '0;
      if (retry_count < RETRY_MAX) begin
        retry_n = retry_count + 1'b1;
        state_n = PLL_RST;
      end else begin
        state_n = EXHAUSTED;
      end
    end

    // Outputs are registered from the next state so they change on the entry edge.
    pll_resetb_n = (state_n == WAIT_LOCK) || (state_n == STABLE) || (state_n == RUN);
    ready_n      = (state_n == RUN) || ((state_n == BYPASS_RUN) && (cnt_n == SETTLE));
    sys_reset_n  = !ready_n;
    fault_n      = (state_n == FAULT) || (state_n == BYPASS_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PLL_RST;
      cnt         <= '0;
      retry_count <= '0;
      pll_resetb  <= 1'b0;
      sys_reset   <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      retry_count <= retry_n;
      pll_resetb  <= pll_resetb_n;
      sys_reset   <= sys_reset_n;
      ready       <= ready_n;
      fault       <= fault_n;
    end
  end

`ifdef PLL_BYPASS_FALLBACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pll_bypass <= 1'b0;
    end else begin
      pll_bypass <= (state_n == BYPASS_RUN);
    end
  end
`else
  assign pll_bypass = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer; status vector is {resetb, sys_reset, ready, fault, bypass, retry[1:0]}.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       pll_resetb, pll_bypass, sys_reset, ready, fault;
  logic [1:0] retry_count;
  logic [6:0] st;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] ST_RESET = 7'b0100000;
`ifdef PLL_BYPASS_FALLBACK_EN
  localparam logic [6:0] ST_EXH      = 7'b0101110;
  localparam logic [6:0] ST_EXH_LATE = 7'b0011110;
`else
  localparam logic [6:0] ST_EXH      = 7'b0101010;
  localparam logic [6:0] ST_EXH_LATE = 7'b0101010;
`endif

  assign st = {pll_resetb, sys_reset, ready, fault, pll_bypass, retry_count};

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .PLL_RESET_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .STABLE_CYCLES       (8),
    .MAX_RETRIES         (2),
    .SYNC_STAGES         (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .pll_resetb  (pll_resetb),
    .pll_bypass  (pll_bypass),
    .sys_reset   (sys_reset),
    .ready       (ready),
    .fault       (fault),
    .retry_count (retry_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pll_locked = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pll_locked = 1'b1;
    tick();
    tick();
    checks++; if (st !== ST_RESET) begin errors++; $display("FAIL reset_values: got %b want %b", st, ST_RESET); end
    reset = 1'b0;
  endtask

  task automatic test_nominal();
    do_reset();
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc == 10) pll_locked = 1'b1;
      tick();
      if (cyc == 3)  begin checks++; if (st !== 7'b0100000) begin errors++; $display("FAIL nominal_rst_hold: got %b want %b", st, 7'b0100000); end end
      if (cyc == 4)  begin checks++; if (st !== 7'b1100000) begin errors++; $display("FAIL nominal_resetb_rise: got %b want %b", st, 7'b1100000); end end
      if (cyc == 19) begin checks++; if (st !== 7'b1100000) begin errors++; $display("FAIL nominal_pre_ready: got %b want %b", st, 7'b1100000); end end
      if (cyc == 20) begin checks++; if (st !== 7'b1010000) begin errors++; $display("FAIL nominal_ready: got %b want %b", st, 7'b1010000); end end
    end
  endtask

  // Continues from RUN left by test_nominal.
  task automatic test_lock_loss_in_run();
    for (int cyc = 1; cyc <= 16; cyc++) begin
      if (cyc == 1) pll_locked = 1'b0;
      if (cyc == 4) pll_locked = 1'b1;
      tick();
      if (cyc == 2)  begin checks++; if (st !== 7'b1010000) begin errors++; $display("FAIL loss_still_run: got %b want %b", st, 7'b1010000); end end
      if (cyc == 3)  begin checks++; if (st !== 7'b0100001) begin errors++; $display("FAIL loss_sys_reset: got %b want %b", st, 7'b0100001); end end
      if (cyc == 7)  begin checks++; if (st !== 7'b1100001) begin errors++; $display("FAIL loss_relock_resetb: got %b want %b", st, 7'b1100001); end end
      if (cyc == 15) begin checks++; if (st !== 7'b1100001) begin errors++; $display("FAIL loss_pre_ready: got %b want %b", st, 7'b1100001); end end
      if (cyc == 16) begin checks++; if (st !== 7'b1010001) begin errors++; $display("FAIL loss_recovered: got %b want %b", st, 7'b1010001); end end
    end
  endtask

  task automatic test_lock_glitch();
    do_reset();
    for (int cyc = 1; cyc <= 15; cyc++) begin
      if (cyc == 6) pll_locked = 1'b1;
      if (cyc == 9) pll_locked = 1'b0;
      tick();
      if (cyc == 10) begin checks++; if (st !== 7'b1100000) begin errors++; $display("FAIL glitch_in_stable: got %b want %b", st, 7'b1100000); end end
      if (cyc == 11) begin checks++; if (st !== 7'b0100001) begin errors++; $display("FAIL glitch_restart: got %b want %b", st, 7'b0100001); end end
      if (cyc == 14) begin checks++; if (st !== 7'b0100001) begin errors++; $display("FAIL glitch_rst_hold: got %b want %b", st, 7'b0100001); end end
      if (cyc == 15) begin checks++; if (st !== 7'b1100001) begin errors++; $display("FAIL glitch_resetb_rise: got %b want %b", st, 7'b1100001); end end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (cyc == 80) pll_locked = 1'b1;
      tick();
      if (cyc == 23)  begin checks++; if (st !== 7'b1100000) begin errors++; $display("FAIL timeout_wait1: got %b want %b", st, 7'b1100000); end end
      if (cyc == 24)  begin checks++; if (st !== 7'b0100001) begin errors++; $display("FAIL timeout_retry1: got %b want %b", st, 7'b0100001); end end
      if (cyc == 47)  begin checks++; if (st !== 7'b1100001) begin errors++; $display("FAIL timeout_wait2: got %b want %b", st, 7'b1100001); end end
      if (cyc == 48)  begin checks++; if (st !== 7'b0100010) begin errors++; $display("FAIL timeout_retry2: got %b want %b", st, 7'b0100010); end end
      if (cyc == 71)  begin checks++; if (st !== 7'b1100010) begin errors++; $display("FAIL timeout_wait3: got %b want %b", st, 7'b1100010); end end
      if (cyc == 72)  begin checks++; if (st !== ST_EXH) begin errors++; $display("FAIL timeout_exhausted: got %b want %b", st, ST_EXH); end end
      if (cyc == 87)  begin checks++; if (st !== ST_EXH) begin errors++; $display("FAIL timeout_settle: got %b want %b", st, ST_EXH); end end
      if (cyc == 88)  begin checks++; if (st !== ST_EXH_LATE) begin errors++; $display("FAIL timeout_after_settle: got %b want %b", st, ST_EXH_LATE); end end
      if (cyc == 100) begin checks++; if (st !== ST_EXH_LATE) begin errors++; $display("FAIL timeout_terminal: got %b want %b", st, ST_EXH_LATE); end end
    end
    // Reset for a single cycle while exhausted.
    reset = 1'b1;
    tick();
    checks++; if (st !== ST_RESET) begin errors++; $display("FAIL reset_mid_fault: got %b want %b", st, ST_RESET); end
    reset = 1'b0;
    tick();
    checks++; if (st !== ST_RESET) begin errors++; $display("FAIL reset_mid_fault_release: got %b want %b", st, ST_RESET); end
  endtask

  // Lock first seen on the very cycle the timeout would fire.
  task automatic test_simultaneous();
    do_reset();
    for (int cyc = 1; cyc <= 32; cyc++) begin
      if (cyc == 22) pll_locked = 1'b1;
      tick();
      if (cyc == 24) begin checks++; if (st !== 7'b1100000) begin errors++; $display("FAIL simul_lock_wins: got %b want %b", st, 7'b1100000); end end
      if (cyc == 32) begin checks++; if (st !== 7'b1010000) begin errors++; $display("FAIL simul_run: got %b want %b", st, 7'b1010000); end end
    end
  endtask

  task automatic test_reset_mid_stable();
    do_reset();
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (cyc == 6) pll_locked = 1'b1;
      tick();
    end
    checks++; if (st !== 7'b1100000) begin errors++; $display("FAIL stable_before_reset: got %b want %b", st, 7'b1100000); end
    reset = 1'b1;
    tick();
    checks++; if (st !== ST_RESET) begin errors++; $display("FAIL reset_mid_stable: got %b want %b", st, ST_RESET); end
    reset = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      tick();
      if (cyc == 3) begin checks++; if (st !== 7'b0100000) begin errors++; $display("FAIL restart_rst_hold: got %b want %b", st, 7'b0100000); end end
      if (cyc == 4) begin checks++; if (st !== 7'b1100000) begin errors++; $display("FAIL restart_resetb_rise: got %b want %b", st, 7'b1100000); end end
    end
  endtask

  initial begin
    reset = 1'b1;
    pll_locked = 1'b0;
    test_reset();
    test_nominal();
    test_lock_loss_in_run();
    test_lock_glitch();
    test_timeout();
    test_simultaneous();
    test_reset_mid_stable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
